// File: rtl/data_unpacker_if.sv
// Handshake/bus bundle for the data unpacker.
// Input side : valid_in, ready_in, vector_in (N lanes), mode_in, count_in.
// Output side: vector_out (N lanes), len_out, first_out, last_out,
//              valid_out, ready_out, err_out.
// slave  = unpacker view, master = producer/consumer view.
interface data_unpacker_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned CW = $clog2(N) + 1;

  logic                         valid_in;
  logic                         ready_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic [1:0]                   mode_in;
  logic [CW-1:0]                count_in;

  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic [CW-1:0]                len_out;
  logic                         first_out;
  logic                         last_out;
  logic                         valid_out;
  logic                         ready_out;
  logic                         err_out;

  modport slave (
    input  valid_in, vector_in, mode_in, count_in, ready_out,
    output ready_in, vector_out, len_out, first_out, last_out, valid_out, err_out
  );

  modport master (
    output valid_in, vector_in, mode_in, count_in, ready_out,
    input  ready_in, vector_out, len_out, first_out, last_out, valid_out, err_out
  );
endinterface

// File: rtl/data_unpacker.sv
// Data unpacker: splits an N-lane packed vector back into blocks of N, M or 1
// values, oldest group first, one block per output handshake.
// Ports:
//   clk    - clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - data_unpacker_if.slave (input vector handshake, output block
//            handshake, err_out pulse for dropped illegal vectors)
module data_unpacker #(
  parameter int unsigned N          = 8,
  parameter int unsigned M          = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            resetn,
  data_unpacker_if.slave bus
);
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = CW + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                       state;
  logic [N-1:0][DATA_WIDTH-1:0] buf_q;
  logic [CW-1:0]                rd_ptr;
  logic [CW-1:0]                groups_left;
  logic [CW-1:0]                len_q;
  logic [CW-1:0]                count_q;
  logic                         err_q;

  logic [CW-1:0] dec_len_c;
  logic [CW-1:0] dec_groups_c;
  logic          legal_c;
  logic          emit_c;
  logic          done_c;
  logic          ready_c;
  logic          accept_c;
  logic [IW-1:0] idx_c;

  // Decode block length, group count and legality of the presented vector.
  always_comb begin
    dec_len_c    = '0;
    dec_groups_c = '0;
    legal_c      = 1'b0;
    case (bus.mode_in)
      2'd0: begin
        dec_len_c    = CW'(N);
        dec_groups_c = CW'(1);
        legal_c      = (bus.count_in == CW'(N));
      end
      2'd1: begin
        dec_len_c    = CW'(M);
        dec_groups_c = bus.count_in / CW'(M);
        legal_c      = (bus.count_in >= CW'(1)) && (bus.count_in <= CW'(N)) &&
                       ((bus.count_in % CW'(M)) == CW'(0));
      end
      2'd2: begin
        dec_len_c    = CW'(1);
        dec_groups_c = bus.count_in;
        legal_c      = (bus.count_in >= CW'(1)) && (bus.count_in <= CW'(N));
      end
      default: ;
    endcase
  end

  // A new vector may enter while the final group is being taken, so vectors
  // stream back-to-back without a bubble.
  assign emit_c   = (state == EMIT);
  assign done_c   = emit_c && bus.ready_out && (groups_left == CW'(1));
  assign ready_c  = (state == IDLE) || done_c;
  assign accept_c = bus.valid_in && ready_c;

  // State machine and holding buffer; illegal vectors are consumed and only
  // raise err_q for one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      buf_q       <= '0;
      rd_ptr      <= '0;
      groups_left <= '0;
      len_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= accept_c && !legal_c;
      if (accept_c && legal_c) begin
        state       <= EMIT;
        buf_q       <= bus.vector_in;
        rd_ptr      <= CW'(N) - bus.count_in;
        groups_left <= dec_groups_c;
        len_q       <= dec_len_c;
        count_q     <= bus.count_in;
      end else if (emit_c && bus.ready_out) begin
        if (groups_left == CW'(1)) begin
          state <= IDLE;
        end else begin
          rd_ptr      <= rd_ptr + len_q;
          groups_left <= groups_left - CW'(1);
        end
      end
    end
  end

  // Current group is lanes [rd_ptr, rd_ptr+len-1] of the buffer, shifted down
  // to lane 0; everything else reads as zero.
  always_comb begin
    bus.vector_out = '0;
    idx_c          = '0;
    for (int j = 0; j < N; j++) begin
      idx_c = IW'(rd_ptr) + IW'(j);
      if (emit_c && (CW'(j) < len_q) && (idx_c < IW'(N))) begin
        bus.vector_out[j] = buf_q[idx_c[AW-1:0]];
      end
    end
  end

  assign bus.ready_in  = ready_c;
  assign bus.valid_out = emit_c;
  assign bus.len_out   = emit_c ? len_q : '0;
  assign bus.first_out = emit_c && (rd_ptr == (CW'(N) - count_q));
  assign bus.last_out  = emit_c && (groups_left == CW'(1));
  assign bus.err_out   = err_q;
endmodule
